if_stage: RTL



---
 rtl/if_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem req/ready handshake, IF/ID pipeline register.
// Latency: one cycle from imem_ready to IF/ID with a zero-wait memory; a stalled response waits in a one-entry buffer.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall, and a pending request is drained before the new fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [5:0]  opcode
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] buffer, buffer_nxt;
    logic [31:0] if_instr_nxt, if_pc4_nxt;
    logic        if_valid_nxt;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_inc   = pc + STEP;

    // Gated with rst_n so the request drops the instant reset asserts.
    assign imem_req  = rst_n & (state != HOLD);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign opcode    = if_instr[31:26];

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        buffer_nxt     = buffer;
        if_instr_nxt   = if_instr;
        if_pc4_nxt     = if_pc4;
        if_valid_nxt   = if_valid;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_nxt       = target;
                    if_valid_nxt = 1'b0;
                    if_instr_nxt = 32'h0;
                    if (!imem_ready) begin
                        drain_addr_nxt = pc;
                        state_nxt      = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        buffer_nxt = imem_rdata;
                        state_nxt  = HOLD;
                    end else begin
                        if_instr_nxt = imem_rdata;
                        if_pc4_nxt   = pc_inc;
                        if_valid_nxt = 1'b1;
                        pc_nxt       = pc_inc;
                    end
                end else if (!stall) begin
                    if_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt       = target;
                    buffer_nxt   = 32'h0;
                    if_valid_nxt = 1'b0;
                    state_nxt    = FETCH;
                end else if (!stall) begin
                    if_instr_nxt = buffer;
                    if_pc4_nxt   = pc_inc;
                    if_valid_nxt = 1'b1;
                    pc_nxt       = pc_inc;
                    state_nxt    = FETCH;
                end
            end
            DRAIN: begin
                // The stale response is discarded; only the newest target survives.
                if (redirect) pc_nxt = target;
                if (imem_ready) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= 32'h0;
            buffer     <= 32'h0;
            if_instr   <= 32'h0;
            if_pc4     <= 32'h0;
            if_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            buffer     <= buffer_nxt;
            if_instr   <= if_instr_nxt;
            if_pc4     <= if_pc4_nxt;
            if_valid   <= if_valid_nxt;
        end
    end

endmodule
